wb_regfile: RTL and testbench

Write-back stage and architectural register file for the five-stage MIPS pipeline. Consumes the registered outputs of the MEM/WB pipeline register, selects the write-back value and destination (including the `jal` link write of PC+4 to `$31`), and commits it to a 32×32 register file on the rising clock edge. Serves the ID stage with two combinational read ports that bypass a same-cycle write, and exposes a debug read port plus a retired-write counter for the bench.

---
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file for the five-stage MIPS pipeline.
// Selects the write-back value (including the jal link write), commits it, and serves bypassed ID reads.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [4:0]  RA_REG  = 5'd31
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        regWrite_in,
    input  logic        regWrite_jal_in,
    input  logic [31:0] PCPlusFour_in,
    input  logic [31:0] RegData_in,
    input  logic [4:0]  RegDst_in,
    input  logic [4:0]  RsAddr,
    input  logic [4:0]  RtAddr,
    output logic [31:0] RsData,
    output logic [31:0] RtData,
    input  logic [4:0]  DbgAddr,
    output logic [31:0] DbgData,
    output logic [31:0] WbCount
);

    localparam logic [4:0] SP_REG = 5'd29;

    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;

    logic [31:0] regs_q [32];
    logic [31:0] wbCount_q;
    logic [31:0] wbCount_d;

    // The jal link write takes over both destination and data whenever it is requested.
    always_comb begin
        wrEn   = regWrite_in | regWrite_jal_in;
        wrAddr = regWrite_jal_in ? RA_REG : RegDst_in;
        wrData = regWrite_jal_in ? PCPlusFour_in : RegData_in;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (5'(i) == SP_REG) ? SP_INIT : 32'd0;
            end
        end else if (wrEn && (wrAddr != 5'd0)) begin
            regs_q[wrAddr] <= wrData;
        end
    end

    // Writes aimed at $0 are dropped above but still retire, so they still count.
    always_comb begin
        wbCount_d = wbCount_q;
        if (wrEn) begin
            wbCount_d = wbCount_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wbCount_q <= 32'd0;
        end else begin
            wbCount_q <= wbCount_d;
        end
    end

    always_comb begin
        RsData = regs_q[RsAddr];
        if (RsAddr == 5'd0) begin
            RsData = 32'd0;
        end else if (wrEn && (wrAddr == RsAddr)) begin
            RsData = wrData;
        end
    end

    always_comb begin
        RtData = regs_q[RtAddr];
        if (RtAddr == 5'd0) begin
            RtData = 32'd0;
        end else if (wrEn && (wrAddr == RtAddr)) begin
            RtData = wrData;
        end
    end

    // Debug port shows committed state only, so it deliberately skips the bypass.
    always_comb begin
        DbgData = (DbgAddr == 5'd0) ? 32'd0 : regs_q[DbgAddr];
        WbCount = wbCount_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile: stimulus pushes expected read values,
// a monitor pops and compares them mid-cycle against the DUT.
module tb_wb_regfile;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        regWrite_in = 1'b0;
    logic        regWrite_jal_in = 1'b0;
    logic [31:0] PCPlusFour_in = '0;
    logic [31:0] RegData_in = '0;
    logic [4:0]  RegDst_in = '0;
    logic [4:0]  RsAddr = '0;
    logic [4:0]  RtAddr = '0;
    logic [4:0]  DbgAddr = '0;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] DbgData;
    logic [31:0] WbCount;

    typedef struct {
        string       tag;
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic [31:0] expDbg;
        logic [31:0] expCnt;
    } expItem_t;

    expItem_t sbQ[$];

    logic [31:0] modelReg [32];
    logic [31:0] modelCnt;

    int total = 0;
    int bad = 0;

    wb_regfile dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .regWrite_in    (regWrite_in),
        .regWrite_jal_in(regWrite_jal_in),
        .PCPlusFour_in  (PCPlusFour_in),
        .RegData_in     (RegData_in),
        .RegDst_in      (RegDst_in),
        .RsAddr         (RsAddr),
        .RtAddr         (RtAddr),
        .RsData         (RsData),
        .RtData         (RtData),
        .DbgAddr        (DbgAddr),
        .DbgData        (DbgData),
        .WbCount        (WbCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a flat array of architectural registers plus a retired-write tally.
    function automatic logic [31:0] modelRead(input logic [4:0] addr, input bit writing,
                                              input logic [4:0] target, input logic [31:0] val);
        if (addr == 5'd0) return 32'd0;
        if (writing && target == addr) return val;
        return modelReg[addr];
    endfunction

    task automatic applyStimulus(input bit rst, input bit we, input bit jal,
                                 input logic [4:0] dst, input logic [31:0] data,
                                 input logic [31:0] pc4, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] dbg,
                                 input string tag);
        expItem_t item;
        bit writing;
        logic [4:0] target;
        logic [31:0] val;
        @(posedge Clk);
        #1;
        Rst_n = rst;
        regWrite_in = we;
        regWrite_jal_in = jal;
        RegDst_in = dst;
        RegData_in = data;
        PCPlusFour_in = pc4;
        RsAddr = rs;
        RtAddr = rt;
        DbgAddr = dbg;
        if (!rst) begin
            for (int i = 0; i < 32; i++) modelReg[i] = (i == 29) ? 32'h0000_3FFC : 32'd0;
            modelCnt = 32'd0;
        end
        writing = we || jal;
        target = jal ? 5'd31 : dst;
        val = jal ? pc4 : data;
        item.tag = tag;
        item.expRs = modelRead(rs, writing, target, val);
        item.expRt = modelRead(rt, writing, target, val);
        item.expDbg = modelReg[dbg];
        item.expCnt = modelCnt;
        sbQ.push_back(item);
        if (rst && writing) begin
            modelCnt = modelCnt + 32'd1;
            if (target != 5'd0) modelReg[target] = val;
        end
    endtask

    initial begin : monitor
        expItem_t item;
        forever begin
            @(negedge Clk);
            if (sbQ.size() > 0) begin
                item = sbQ.pop_front();
                checkOutput({item.tag, ".rs"}, RsData, item.expRs);
                checkOutput({item.tag, ".rt"}, RtData, item.expRt);
                checkOutput({item.tag, ".dbg"}, DbgData, item.expDbg);
                checkOutput({item.tag, ".cnt"}, WbCount, item.expCnt);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int budget;
        logic [4:0] d;
        #1 Rst_n = 1'b0;
        for (int i = 0; i < 32; i++) modelReg[i] = 32'd0;
        modelCnt = 32'd0;

        $display("[TB] reset sweep after power-up");
        for (int a = 0; a < 32; a++)
            applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(31 - a), 5'(a), "rst0");

        applyStimulus(1, 1, 0, 5'd8, 32'hDEAD_BEEF, 32'd0, 5'd8, 5'd8, 5'd8, "wr8");
        applyStimulus(1, 0, 0, 5'd8, 32'h1234_5678, 32'd0, 5'd8, 5'd8, 5'd8, "nowr");
        applyStimulus(1, 1, 1, 5'd5, 32'h1111_1111, 32'h0040_0024, 5'd31, 5'd5, 5'd31, "jal");
        applyStimulus(1, 0, 1, 5'd5, 32'h1111_1111, 32'h0040_0028, 5'd31, 5'd5, 5'd31, "jalOnly");
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd5, 5'd5, "jalChk");
        applyStimulus(1, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0, "wr0");
        applyStimulus(1, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd29, 5'd0, "wr0Chk");
        for (int v = 1; v <= 3; v++)
            applyStimulus(1, 1, 0, 5'd3, 32'(v), 32'd0, 5'd29, 5'd3, 5'd3, "b2b");
        applyStimulus(1, 0, 0, 5'd3, 32'd0, 32'd0, 5'd29, 5'd3, 5'd3, "b2bChk");

        // Preload the counter near its limit to exercise the wrap without 2^32 writes.
        @(posedge Clk);
        #1;
        regWrite_in = 1'b0;
        regWrite_jal_in = 1'b0;
        force dut.wbCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.wbCount_q;
        modelCnt = 32'hFFFF_FFFF;
        applyStimulus(1, 1, 0, 5'd9, 32'hA5A5_0001, 32'd0, 5'd9, 5'd9, 5'd9, "wrap");
        applyStimulus(1, 0, 0, 5'd9, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9, "wrapChk");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            d = 5'($urandom);
            applyStimulus(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                          d, $urandom, $urandom,
                          ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
                          ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
                          5'($urandom), "rand");
        end

        $display("[TB] reset asserted mid-run");
        applyStimulus(0, 1, 0, 5'd8, 32'hCAFE_F00D, 32'd0, 5'd8, 5'd29, 5'd0, "rstWr");
        for (int a = 0; a < 32; a++)
            applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'(a), 5'd8, 5'(a), "rst1");
        applyStimulus(1, 1, 0, 5'd29, 32'h0000_1000, 32'd0, 5'd29, 5'd8, 5'd29, "postRst");
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd29, 5'd8, 5'd29, "postRstChk");

        budget = 0;
        while (sbQ.size() > 0 && budget < 10) begin
            @(posedge Clk);
            budget++;
        end
        @(posedge Clk);
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
